// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer: FSM state encodings visible on o_state.
package interval_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/counter_mod_n.sv
// Library modulo-N counter: counts 0..N-1 while enabled and flags the wrapping cycle.
module counter_mod_n #(
  parameter int N = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_wrap
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] count_q;

  // Wrap is combinational so the parent sees it in the same cycle as the terminal count.
  assign o_wrap = i_enable && (count_q == CW'(N - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (i_enable) begin
      count_q <= o_wrap ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: prescaled down-counter sequenced by start/stop/clear,
// with one-shot or auto-reload operation, a registered done pulse and a sticky irq.
module interval_timer_ctrl #(
  parameter int PRESCALE = 25000,
  parameter int WIDTH    = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_clear,
  input  logic             i_reload,
  input  logic [WIDTH-1:0] i_period,
  input  logic             i_irq_ack,
  output logic [WIDTH-1:0] o_count,
  output logic [1:0]       o_state,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_irq
);

  import interval_timer_ctrl_pkg::*;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             irq_q, irq_d;

  logic idle_like;
  logic start_cmd;
  logic start_load;
  logic enable;
  logic tick;
  logic pre_reset;

  // Command decode with clear > stop > start priority.
  always_comb begin
    idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    start_cmd  = i_start && !i_stop && !i_clear;
    start_load = start_cmd && idle_like && (i_period != '0);
    enable     = (state_q == ST_RUN) && !i_stop && !i_clear;
    pre_reset  = i_reset || i_clear || start_load;
  end

  counter_mod_n #(
    .N(PRESCALE)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_reset (pre_reset),
    .i_enable(enable),
    .o_wrap  (tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    irq_d    = irq_q && !i_irq_ack;

    if (i_clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_load) begin
            period_d = i_period;
            mode_d   = i_reload;
            count_d  = i_period;
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              // Expiry: an ack in this same cycle must not hide the new event.
              done_d = 1'b1;
              irq_d  = 1'b1;
              if (mode_q) begin
                count_d = period_q;
              end else begin
                count_d = '0;
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (start_cmd) begin
            state_d = ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
    end
  end

  assign o_count = count_q;
  assign o_state = state_q;
  assign o_busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign o_done  = done_q;
  assign o_irq   = irq_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed scoreboard bench for interval_timer_ctrl with PRESCALE=4, WIDTH=8.
module tb_interval_timer_ctrl;

  localparam int PRESCALE = 4;
  localparam int WIDTH    = 8;

  localparam int K_COUNT = 0;
  localparam int K_STATE = 1;
  localparam int K_DONE  = 2;
  localparam int K_IRQ   = 3;
  localparam int K_BUSY  = 4;

  logic             clk = 1'b0;
  logic             i_reset = 1'b0;
  logic             i_start = 1'b0;
  logic             i_stop = 1'b0;
  logic             i_clear = 1'b0;
  logic             i_reload = 1'b0;
  logic [WIDTH-1:0] i_period = '0;
  logic             i_irq_ack = 1'b0;
  logic [WIDTH-1:0] o_count;
  logic [1:0]       o_state;
  logic             o_busy;
  logic             o_done;
  logic             o_irq;

  typedef struct {
    int          at;
    string       tag;
    int          kind;
    logic [7:0]  val;
  } exp_t;

  exp_t sb[$];
  int   now;
  int   check_count;
  int   pass_count;

  interval_timer_ctrl #(
    .PRESCALE(PRESCALE),
    .WIDTH   (WIDTH)
  ) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .i_stop   (i_stop),
    .i_clear  (i_clear),
    .i_reload (i_reload),
    .i_period (i_period),
    .i_irq_ack(i_irq_ack),
    .o_count  (o_count),
    .o_state  (o_state),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_irq    (o_irq)
  );

  always #5 clk = ~clk;

  task automatic expect_at(input int at, input string tag, input int kind, input logic [7:0] val);
    exp_t e;
    e.at   = at;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] observe(input int kind);
    logic [7:0] v;
    v = 8'hxx;
    case (kind)
      K_COUNT: v = o_count;
      K_STATE: v = {6'd0, o_state};
      K_DONE:  v = {7'd0, o_done};
      K_IRQ:   v = {7'd0, o_irq};
      K_BUSY:  v = {7'd0, o_busy};
      default: v = 8'hxx;
    endcase
    return v;
  endfunction

  // Pop every expectation due in the current cycle and compare it with the DUT.
  task automatic checkOutput();
    logic [7:0] obs;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == now) begin
        obs = observe(sb[i].kind);
        check_count++;
        assert (obs === sb[i].val) pass_count++;
        else $error("[TB] FAIL %s @%0d: observed %0h expected %0h", sb[i].tag, now, obs, sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge sample them, then check outputs.
  task automatic applyStimulus(input logic start, input logic stop, input logic clear,
                               input logic reload, input logic [7:0] period, input logic ack);
    i_start   = start;
    i_stop    = stop;
    i_clear   = clear;
    i_reload  = reload;
    i_period  = period;
    i_irq_ack = ack;
    @(posedge clk);
    #1;
    now++;
    i_start   = 1'b0;
    i_stop    = 1'b0;
    i_clear   = 1'b0;
    i_reload  = 1'b0;
    i_period  = '0;
    i_irq_ack = 1'b0;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    check_count = 0;
    pass_count  = 0;

    // Reset held for three cycles.
    now = 0;
    expect_at(3, "rst_state", K_STATE, 8'd0);
    expect_at(3, "rst_count", K_COUNT, 8'd0);
    expect_at(3, "rst_done",  K_DONE,  8'd0);
    expect_at(3, "rst_irq",   K_IRQ,   8'd0);
    expect_at(3, "rst_busy",  K_BUSY,  8'd0);
    i_reset = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    i_reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // One-shot, P=3.
    now = 0;
    expect_at(1,  "os_state_run", K_STATE, 8'd1);
    expect_at(1,  "os_busy",      K_BUSY,  8'd1);
    expect_at(1,  "os_cnt1",      K_COUNT, 8'd3);
    expect_at(5,  "os_cnt5",      K_COUNT, 8'd2);
    expect_at(9,  "os_cnt9",      K_COUNT, 8'd1);
    expect_at(13, "os_cnt13",     K_COUNT, 8'd0);
    expect_at(12, "os_irq12",     K_IRQ,   8'd0);
    expect_at(13, "os_irq13",     K_IRQ,   8'd1);
    expect_at(13, "os_state13",   K_STATE, 8'd3);
    expect_at(14, "os_state14",   K_STATE, 8'd3);
    expect_at(13, "os_busy13",    K_BUSY,  8'd0);
    expect_at(15, "os_ack",       K_IRQ,   8'd0);
    for (int c = 1; c <= 14; c++) expect_at(c, "os_done", K_DONE, {7'd0, c == 13});
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0);
    repeat (13) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // Auto-reload, P=2, with irq ack interplay and a final clear.
    now = 0;
    for (int c = 1; c <= 26; c++) expect_at(c, "ar_done", K_DONE, {7'd0, c == 9 || c == 17 || c == 25});
    expect_at(1,  "ar_cnt1",    K_COUNT, 8'd2);
    expect_at(5,  "ar_cnt5",    K_COUNT, 8'd1);
    expect_at(8,  "ar_cnt8",    K_COUNT, 8'd1);
    expect_at(9,  "ar_cnt9",    K_COUNT, 8'd2);
    expect_at(13, "ar_cnt13",   K_COUNT, 8'd1);
    expect_at(17, "ar_cnt17",   K_COUNT, 8'd2);
    expect_at(21, "ar_cnt21",   K_COUNT, 8'd1);
    expect_at(25, "ar_cnt25",   K_COUNT, 8'd2);
    expect_at(9,  "ar_state9",  K_STATE, 8'd1);
    expect_at(17, "ar_state17", K_STATE, 8'd1);
    expect_at(25, "ar_state25", K_STATE, 8'd1);
    expect_at(9,  "ar_irq9",    K_IRQ,   8'd1);
    expect_at(10, "ar_irq10",   K_IRQ,   8'd0);
    expect_at(17, "ar_irq_setwins", K_IRQ, 8'd1);
    expect_at(18, "ar_irq_ack", K_IRQ,   8'd0);
    expect_at(25, "ar_irq25",   K_IRQ,   8'd1);
    expect_at(26, "ar_clr_state", K_STATE, 8'd0);
    expect_at(26, "ar_clr_count", K_COUNT, 8'd0);
    expect_at(26, "ar_clr_irq",   K_IRQ,   8'd1);
    expect_at(26, "ar_clr_busy",  K_BUSY,  8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0);
    while (now < 26) begin
      applyStimulus(1'b0, 1'b0, (now + 1 == 26), 1'b0, 8'd0,
                    (now + 1 == 10) || (now + 1 == 17) || (now + 1 == 18));
    end

    // Pause/resume, P=3 one-shot; start in RUN and stop in PAUSE are ignored.
    now = 0;
    expect_at(3,  "pa_cnt3",      K_COUNT, 8'd3);
    expect_at(5,  "pa_cnt5",      K_COUNT, 8'd2);
    expect_at(6,  "pa_state6",    K_STATE, 8'd1);
    expect_at(7,  "pa_state7",    K_STATE, 8'd2);
    expect_at(7,  "pa_busy7",     K_BUSY,  8'd1);
    expect_at(7,  "pa_cnt7",      K_COUNT, 8'd2);
    expect_at(11, "pa_cnt11",     K_COUNT, 8'd2);
    expect_at(12, "pa_state12",   K_STATE, 8'd2);
    expect_at(13, "pa_done13",    K_DONE,  8'd0);
    expect_at(15, "pa_cnt15",     K_COUNT, 8'd2);
    expect_at(15, "pa_state15",   K_STATE, 8'd2);
    expect_at(16, "pa_state16",   K_STATE, 8'd1);
    expect_at(16, "pa_cnt16",     K_COUNT, 8'd2);
    expect_at(18, "pa_cnt18",     K_COUNT, 8'd2);
    expect_at(19, "pa_cnt19",     K_COUNT, 8'd1);
    expect_at(22, "pa_done22",    K_DONE,  8'd0);
    expect_at(23, "pa_done23",    K_DONE,  8'd1);
    expect_at(23, "pa_cnt23",     K_COUNT, 8'd0);
    expect_at(23, "pa_state23",   K_STATE, 8'd3);
    expect_at(24, "pa_done24",    K_DONE,  8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0);
    while (now < 24) begin
      if (now + 1 == 3)       applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd9, 1'b0);
      else if (now + 1 == 7)  applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      else if (now + 1 == 12) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      else if (now + 1 == 16) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      else                    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    end

    // Edge commands: zero-period starts, clear priority.
    now = 0;
    expect_at(1, "ec_p0_done_state", K_STATE, 8'd3);
    expect_at(2, "ec_clr_state",     K_STATE, 8'd0);
    expect_at(2, "ec_clr_count",     K_COUNT, 8'd0);
    expect_at(2, "ec_clr_irq",       K_IRQ,   8'd1);
    expect_at(3, "ec_p0_idle_state", K_STATE, 8'd0);
    expect_at(3, "ec_p0_idle_count", K_COUNT, 8'd0);
    expect_at(3, "ec_p0_idle_busy",  K_BUSY,  8'd0);
    expect_at(4, "ec_start_state",   K_STATE, 8'd1);
    expect_at(4, "ec_start_count",   K_COUNT, 8'd5);
    expect_at(6, "ec_cnt6",          K_COUNT, 8'd5);
    expect_at(7, "ec_all_state",     K_STATE, 8'd0);
    expect_at(7, "ec_all_count",     K_COUNT, 8'd0);
    expect_at(7, "ec_all_busy",      K_BUSY,  8'd0);
    expect_at(7, "ec_all_done",      K_DONE,  8'd0);
    expect_at(8, "ec_idle_state",    K_STATE, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd7, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Any expectation never reached counts as a failure.
    for (int i = 0; i < sb.size(); i++) begin
      check_count++;
      $display("[TB] FAIL %s: observed never-checked expected check at cycle %0d", sb[i].tag, sb[i].at);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/interval_timer_ctrl.md
# interval_timer_ctrl

Programmable interval timer controller for the shared library. It sequences a prescaled down-counter through IDLE/RUN/PAUSE/DONE under start, stop and clear pulses, with one-shot or auto-reload operation. It produces a one-cycle done pulse and a sticky interrupt flag. It sits between user-facing controls (debounced buttons, UART command decoder) and display or LED logic in the lab designs.

## Interface
- PRESCALE, 25000, system clocks per timer tick; must be ≥ 2.
- WIDTH, 16, width of period and count.

- i_clk  in  1  system clock.
- i_reset  in  1  reset. Synchronous, active-high.
- i_start  in  1  start/resume pulse.
- i_stop  in  1  pause pulse.
- i_clear  in  1  abort to IDLE.
- i_reload  in  1  mode, sampled only on a start from IDLE/DONE: 1 = auto-reload, 0 = one-shot.
- i_period  in  WIDTH  tick count, sampled only on a start from IDLE/DONE.
- i_irq_ack  in  1  clears o_irq.
- o_count  out  WIDTH  remaining ticks.
- o_state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- o_busy  out  1  high when state is RUN or PAUSE.
- o_done  out  1  one-cycle expiry pulse, registered.
- o_irq  out  1  sticky expiry flag.

## Operation
- Reset values: state IDLE, o_count 0, o_done 0, o_irq 0, prescaler 0, latched period 0, latched mode 0.
- Command priority when asserted in the same cycle: clear > stop > start.
- IDLE or DONE, start with i_period ≠ 0:
  - latch i_period and i_reload;
  - o_count ← i_period, prescaler ← 0, go to RUN.
- IDLE or DONE, start with i_period = 0: ignored; state, count and latched values are unchanged.
- RUN:
  - i_stop → PAUSE;
  - i_start → ignored.
- PAUSE:
  - i_start → RUN, resuming from the held prescaler and count values; no reload.
  - i_stop → ignored.
- Clear in any state → IDLE, o_count 0, prescaler 0. o_irq is not affected.
- Prescaler: counts 0..PRESCALE-1 and wraps.
  - Enable = (state==RUN) && !i_stop && !i_clear.
  - tick = enable && prescaler==PRESCALE-1.
- On tick with o_count > 1: decrement o_count.
- On tick with o_count == 1 (expiry):
  - o_done ← 1 for one cycle, o_irq ← 1;
  - auto-reload: o_count ← latched period, stay in RUN;
  - one-shot: o_count ← 0, go to DONE.
- o_irq:
  - set on expiry, cleared by i_irq_ack;
  - if set and ack occur in the same cycle, set wins;
  - cleared only by i_reset or i_irq_ack.
- Arithmetic: the decrement never underflows, because o_count is ≥ 1 whenever state is RUN.

## Timing
- Start sampled at edge t → RUN and o_count = P are visible from cycle t+1.
- The k-th decrement is visible at t + k·PRESCALE + 1.
- Expiry (o_done high, o_irq high, o_count 0 or P) is visible at t + P·PRESCALE + 1.
- Auto-reload: subsequent o_done pulses arrive exactly every P·PRESCALE cycles.
- Stop sampled at cycle s, start sampled at cycle r → expiry is delayed by exactly r − s + 1 cycles.
- No combinational path from inputs to outputs.

## Structure
- Shared package/header holds the state encodings (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE).
- One sub-module: the library counter_mod_n with N = PRESCALE, used as the prescaler.
  - i_enable = enable.
  - i_reset = i_reset | clear | (start accepted from IDLE/DONE).
  - o_wrap = tick.
- FSM and down-counter live in interval_timer_ctrl. Expected size is 150–250 lines.

## Test plan
All scenarios use PRESCALE=4, WIDTH=8; cycle numbers are relative to the start pulse at cycle 0.
- Reset: hold i_reset 3 cycles → o_state 0, o_count 0, o_done 0, o_irq 0, o_busy 0.
- One-shot, P=3:
  - o_count reads 3 @1, 2 @5, 1 @9, 0 @13;
  - o_done high only @13; o_irq=1 and o_state=DONE from 13.
- Auto-reload, P=2: o_done pulses @9, 17 and 25; o_count reloads to 2 on each; o_state stays RUN.
- Pause, P=3 one-shot: stop @6, start @15 → count frozen during 7..15; o_done @23.
- Edge commands:
  - start with P=0 from IDLE → no state change;
  - start+stop+clear together in RUN → IDLE, o_count 0;
  - start during RUN → ignored.
- IRQ: i_irq_ack in the same cycle as an auto-reload expiry → o_irq stays 1; a lone ack next cycle → o_irq 0; clear leaves o_irq at 1.
